// File: rtl/decode_secret_if.sv
// rtl/decode_secret_if.sv - image-read and result bus between the decoder and its surroundings
interface decode_secret_if;
  logic          start;
  logic [5:0]    row;
  logic [5:0]    col;
  logic [23:0]   enc_pix;
  logic [23:0]   ref_pix;
  logic [4095:0] hidden_string;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, enc_pix, ref_pix,
    input  row, col, hidden_string, busy, done, err
  );

  modport slave (
    input  start, enc_pix, ref_pix,
    output row, col, hidden_string, busy, done, err
  );
endinterface

// File: rtl/decode_secret.sv
// rtl/decode_secret.sv - recovers the 4096-bit hidden string from an encoded 64x64 image
module decode_secret (
  input logic           clk,
  input logic           rst,
  decode_secret_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CAPT, S_FIND, S_DIGIT, S_CONV, S_STORE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]       blk;      // block index, {block_row, block_col}
  logic [3:0]       pos;      // in-block position, {r_m, c_m}
  logic [5:0]       row_q, col_q;
  logic [23:0]      r_buf [16];
  logic [7:0]       e_g [16]; // only the green channel of the encoded pixel carries data
  logic [3:0]       pos_lm, pos_hm;
  logic [13:0][1:0] dig_q;
  logic [22:0]      acc;
  logic [3:0]       k;
  logic [4095:0]    hid_q;
  logic             err_q;

  logic             start_ok;
  logic [3:0]       f_pos_lm, f_pos_hm;
  logic [13:0][1:0] dig_c;
  logic             bad_c;
  logic [7:0]       blk_nx;
  logic             unused_pix;

  assign start_ok = bus.start && (state == S_IDLE || state == S_DONE);
  assign blk_nx   = blk + 8'd1;
  assign unused_pix = ^{bus.enc_pix[23:16], bus.enc_pix[7:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: one block is 16 x (ADDR, CAPT), then FIND, DIGIT, 14 x CONV, STORE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = S_ADDR;
      S_ADDR:  state_nx = S_CAPT;
      S_CAPT:  state_nx = (pos == 4'd15) ? S_FIND : S_ADDR;
      S_FIND:  state_nx = S_DIGIT;
      S_DIGIT: state_nx = S_CONV;
      S_CONV:  state_nx = (k == 4'd0) ? S_STORE : S_CONV;
      S_STORE: state_nx = (blk == 8'd255) ? S_DONE : S_ADDR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state alone
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_IDLE:  ;
      S_DONE:  bus.done = 1'b1;
      default: bus.busy = 1'b1;
    endcase
  end

  // Locate Lm/Hm: the first pixel differing from R[0][0] is the other extreme of the block
  always_comb begin
    logic        found;
    logic [23:0] hm0;
    logic [3:0]  kpos;
    found    = 1'b0;
    hm0      = r_buf[0];
    kpos     = 4'd1;
    f_pos_lm = 4'd0;
    f_pos_hm = 4'd1;
    for (int i = 1; i < 16; i++) begin
      if (!found && r_buf[i] != r_buf[0]) begin
        found = 1'b1;
        hm0   = r_buf[i];
        kpos  = 4'(i);
      end
    end
    if (found) begin
      if (r_buf[0] > hm0) begin
        f_pos_lm = kpos;
        f_pos_hm = 4'd0;
      end else begin
        f_pos_lm = 4'd0;
        f_pos_hm = kpos;
      end
    end
  end

  // Extract the 14 base-3 digits from the green difference, skipping the Lm/Hm pixels
  always_comb begin
    logic [3:0] n;
    logic [7:0] diff;
    dig_c = '0;
    bad_c = 1'b0;
    n     = 4'd0;
    diff  = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) != pos_lm && 4'(i) != pos_hm) begin
        diff = e_g[i] - r_buf[i][15:8];
        case (diff)
          8'h00:   dig_c[n] = 2'd0;
          8'h01:   dig_c[n] = 2'd1;
          8'hFF:   dig_c[n] = 2'd2;
          default: begin
            dig_c[n] = 2'd0;
            bad_c    = 1'b1;
          end
        endcase
        n = n + 4'd1;
      end
    end
  end

  // Block buffers capture the pixel pair addressed in the previous ADDR cycle
  always_ff @(posedge clk) begin
    if (state == S_CAPT) begin
      r_buf[pos] <= bus.ref_pix;
      e_g[pos]   <= bus.enc_pix[15:8];
    end
  end

  // Addressing, digit conversion and result storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk    <= 8'd0;
      pos    <= 4'd0;
      row_q  <= 6'd0;
      col_q  <= 6'd0;
      pos_lm <= 4'd0;
      pos_hm <= 4'd1;
      dig_q  <= '0;
      acc    <= 23'd0;
      k      <= 4'd0;
      hid_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            blk   <= 8'd0;
            pos   <= 4'd0;
            row_q <= 6'd0;
            col_q <= 6'd0;
            hid_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_CAPT: begin
          if (pos != 4'd15) begin
            pos   <= pos + 4'd1;
            row_q <= {blk[7:4], pos_inc(pos, 1'b1)};
            col_q <= {blk[3:0], pos_inc(pos, 1'b0)};
          end
        end
        S_FIND: begin
          pos_lm <= f_pos_lm;
          pos_hm <= f_pos_hm;
        end
        S_DIGIT: begin
          dig_q <= dig_c;
          acc   <= 23'd0;
          k     <= 4'd13;
          if (bad_c) err_q <= 1'b1;
        end
        S_CONV: begin
          acc <= acc * 23'd3 + {21'd0, dig_q[k]};
          k   <= k - 4'd1;
        end
        S_STORE: begin
          if (acc > 23'd65535) begin
            hid_q[{blk, 4'b0000} +: 16] <= 16'hFFFF;
            err_q                       <= 1'b1;
          end else begin
            hid_q[{blk, 4'b0000} +: 16] <= acc[15:0];
          end
          blk <= blk_nx;
          pos <= 4'd0;
          if (blk != 8'd255) begin
            row_q <= {blk_nx[7:4], 2'b00};
            col_q <= {blk_nx[3:0], 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

  // Next in-block row (sel=1) or column (sel=0) after advancing one raster step
  function automatic logic [1:0] pos_inc(input logic [3:0] p, input logic sel);
    logic [3:0] q;
    q = p + 4'd1;
    return sel ? q[3:2] : q[1:0];
  endfunction

  assign bus.row           = row_q;
  assign bus.col           = col_q;
  assign bus.hidden_string = hid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_decode_secret.sv
// tb/tb_decode_secret.sv - directed self-checking bench for decode_secret
module tb_decode_secret;

  logic clk = 1'b0;
  logic rst;

  decode_secret_if bus_if ();

  logic [23:0] enc_img [64][64];
  logic [23:0] ref_img [64][64];

  assign bus_if.enc_pix = enc_img[bus_if.row][bus_if.col];
  assign bus_if.ref_pix = ref_img[bus_if.row][bus_if.col];

  decode_secret dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int FULL_CYCLES = 12545;

  task automatic fill_images(input logic [23:0] v);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        enc_img[r][c] = v;
        ref_img[r][c] = v;
      end
  endtask

  // Block 0 holds 5, block 1 holds 1, everything else 0
  task automatic load_small_normal();
    fill_images(24'h004000);
    enc_img[0][2] = 24'h003F00;
    enc_img[0][3] = 24'h004100;
    for (int r = 0; r < 4; r++)
      for (int c = 4; c < 8; c++) begin
        enc_img[r][c] = 24'h002000;
        ref_img[r][c] = 24'h002000;
      end
    enc_img[0][4] = 24'h008000;
    ref_img[0][4] = 24'h008000;
    enc_img[0][6] = 24'h002100;
  endtask

  function automatic int first_diff(input logic [4095:0] a, input logic [4095:0] b);
    for (int i = 0; i < 256; i++)
      if (a[16*i +: 16] !== b[16*i +: 16]) return i;
    return 0;
  endfunction

  // Pulse start, optionally pulse it again at cycle mid_start, wait (bounded) for done
  task automatic run_decode(input int mid_start, output int cycles,
                            output logic b1, output logic d1, output logic e1);
    int n;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n  = 1;
    b1 = bus_if.busy;
    d1 = bus_if.done;
    e1 = bus_if.err;
    while (!bus_if.done && n < 13000) begin
      @(posedge clk); #1;
      n++;
      bus_if.start = (n == mid_start);
    end
    bus_if.start = 1'b0;
    cycles = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    fill_images(24'h004000);
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus_if.row !== 6'd0) begin tests_failed++; $display("FAIL reset_row got %0d exp 0", bus_if.row); end
    tests_run++; if (bus_if.col !== 6'd0) begin tests_failed++; $display("FAIL reset_col got %0d exp 0", bus_if.col); end
    tests_run++; if (bus_if.hidden_string !== 4096'd0) begin tests_failed++; $display("FAIL reset_hidden nonzero slice %0d", first_diff(bus_if.hidden_string, 4096'd0)); end
    tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus_if.busy); end
    tests_run++; if (bus_if.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", bus_if.done); end
    tests_run++; if (bus_if.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b exp 0", bus_if.err); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy got %b exp 0", bus_if.busy); end
  endtask

  task automatic test_no_hidden();
    int cyc;
    logic b1, d1, e1;
    fill_images(24'h004000);
    run_decode(0, cyc, b1, d1, e1);
    tests_run++; if (b1 !== 1'b1) begin tests_failed++; $display("FAIL nh_busy_after_start got %b exp 1", b1); end
    tests_run++; if (d1 !== 1'b0) begin tests_failed++; $display("FAIL nh_done_after_start got %b exp 0", d1); end
    tests_run++; if (cyc !== FULL_CYCLES) begin tests_failed++; $display("FAIL nh_latency got %0d exp %0d", cyc, FULL_CYCLES); end
    tests_run++; if (bus_if.hidden_string !== 4096'd0) begin tests_failed++; $display("FAIL nh_hidden slice %0d got %h exp 0000", first_diff(bus_if.hidden_string, 4096'd0), bus_if.hidden_string[16*first_diff(bus_if.hidden_string, 4096'd0) +: 16]); end
    tests_run++; if (bus_if.err !== 1'b0) begin tests_failed++; $display("FAIL nh_err got %b exp 0", bus_if.err); end
    tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL nh_busy_at_done got %b exp 0", bus_if.busy); end
    tests_run++; if (bus_if.row !== 6'd63 || bus_if.col !== 6'd63) begin tests_failed++; $display("FAIL nh_last_addr got %0d,%0d exp 63,63", bus_if.row, bus_if.col); end
  endtask

  task automatic test_small_normal_and_busy_start();
    int cyc;
    logic b1, d1, e1;
    logic [4095:0] exp_s;
    int fd;
    load_small_normal();
    exp_s = '0;
    exp_s[15:0]  = 16'h0005;
    exp_s[31:16] = 16'h0001;
    run_decode(500, cyc, b1, d1, e1);
    tests_run++; if (cyc !== FULL_CYCLES) begin tests_failed++; $display("FAIL busy_start_latency got %0d exp %0d", cyc, FULL_CYCLES); end
    fd = first_diff(bus_if.hidden_string, exp_s);
    tests_run++; if (bus_if.hidden_string !== exp_s) begin tests_failed++; $display("FAIL small_normal slice %0d got %h exp %h", fd, bus_if.hidden_string[16*fd +: 16], exp_s[16*fd +: 16]); end
    tests_run++; if (bus_if.err !== 1'b0) begin tests_failed++; $display("FAIL small_normal_err got %b exp 0", bus_if.err); end
  endtask

  task automatic test_overflow();
    int cyc;
    logic b1, d1, e1;
    logic [4095:0] exp_s;
    int fd;
    fill_images(24'h004000);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r != 0 || c > 1) enc_img[r][c] = 24'h003F00;
    exp_s = '0;
    exp_s[15:0] = 16'hFFFF;
    run_decode(0, cyc, b1, d1, e1);
    tests_run++; if (d1 !== 1'b0) begin tests_failed++; $display("FAIL restart_clears_done got %b exp 0", d1); end
    fd = first_diff(bus_if.hidden_string, exp_s);
    tests_run++; if (bus_if.hidden_string !== exp_s) begin tests_failed++; $display("FAIL overflow slice %0d got %h exp %h", fd, bus_if.hidden_string[16*fd +: 16], exp_s[16*fd +: 16]); end
    tests_run++; if (bus_if.err !== 1'b1) begin tests_failed++; $display("FAIL overflow_err got %b exp 1", bus_if.err); end
  endtask

  task automatic test_illegal();
    int cyc;
    logic b1, d1, e1;
    fill_images(24'h004000);
    enc_img[1][21] = 24'h004200;
    run_decode(0, cyc, b1, d1, e1);
    tests_run++; if (e1 !== 1'b0) begin tests_failed++; $display("FAIL restart_clears_err got %b exp 0", e1); end
    tests_run++; if (cyc !== FULL_CYCLES) begin tests_failed++; $display("FAIL illegal_latency got %0d exp %0d", cyc, FULL_CYCLES); end
    tests_run++; if (bus_if.hidden_string !== 4096'd0) begin tests_failed++; $display("FAIL illegal_hidden slice %0d nonzero", first_diff(bus_if.hidden_string, 4096'd0)); end
    tests_run++; if (bus_if.err !== 1'b1) begin tests_failed++; $display("FAIL illegal_err got %b exp 1", bus_if.err); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int cyc;
    logic b1, d1, e1;
    logic [4095:0] exp_s;
    int fd;
    load_small_normal();
    exp_s = '0;
    exp_s[15:0]  = 16'h0005;
    exp_s[31:16] = 16'h0001;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n = 1;
    while (n < 188) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++; if (bus_if.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy got %b exp 1", bus_if.busy); end
    tests_run++; if (bus_if.hidden_string[15:0] !== 16'h0005) begin tests_failed++; $display("FAIL mid_block0 got %h exp 0005", bus_if.hidden_string[15:0]); end
    rst = 1'b1;
    #1;
    tests_run++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin tests_failed++; $display("FAIL rst_status got busy=%b done=%b err=%b exp 0,0,0", bus_if.busy, bus_if.done, bus_if.err); end
    tests_run++; if (bus_if.hidden_string !== 4096'd0) begin tests_failed++; $display("FAIL rst_hidden nonzero slice %0d", first_diff(bus_if.hidden_string, 4096'd0)); end
    tests_run++; if (bus_if.row !== 6'd0 || bus_if.col !== 6'd0) begin tests_failed++; $display("FAIL rst_addr got %0d,%0d exp 0,0", bus_if.row, bus_if.col); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus_if.busy !== 1'b0) begin tests_failed++; $display("FAIL post_rst_busy got %b exp 0", bus_if.busy); end
    run_decode(0, cyc, b1, d1, e1);
    tests_run++; if (cyc !== FULL_CYCLES) begin tests_failed++; $display("FAIL post_rst_latency got %0d exp %0d", cyc, FULL_CYCLES); end
    fd = first_diff(bus_if.hidden_string, exp_s);
    tests_run++; if (bus_if.hidden_string !== exp_s) begin tests_failed++; $display("FAIL post_rst_hidden slice %0d got %h exp %h", fd, bus_if.hidden_string[16*fd +: 16], exp_s[16*fd +: 16]); end
    tests_run++; if (bus_if.err !== 1'b0) begin tests_failed++; $display("FAIL post_rst_err got %b exp 0", bus_if.err); end
  endtask

  initial begin
    test_reset();
    test_no_hidden();
    test_small_normal_and_busy_start();
    test_overflow();
    test_illegal();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_secret.md
# decode_secret

Recovers the hidden string from an encoded 64x64 image. It is the downstream consumer of the encoding stage. It walks the encoded image and the compressed (pre-encode) image block by block, in 4x4 blocks taken in raster order. For each block it extracts the per-pixel base-3 digits and converts the 14 digits back to a 16-bit word. The 256 resulting words form the 4096-bit string that the encoder was given.

## Interface
- No parameters. Image 64x64, block 4x4, 256 blocks, 16 bits per block: all fixed.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse that starts a decode. Ignored while `busy`.
- `row`, `col`  out  6 each  pixel address, shared by both image memories.
- `enc_pix`  in  24  encoded image pixel at [`row`,`col`] (R 23:16, G 15:8, B 7:0).
- `ref_pix`  in  24  compressed image pixel at the same address.
- `hidden_string`  out  4096  decoded string. Block b occupies bits [16b+15:16b], with b = 16*block_row + block_col.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` rises.
- `done`  out  1  level. Set when the last block has been stored. Cleared by the next accepted `start`.
- `err`  out  1  sticky. Set on any illegal pixel difference or word overflow in the current run. Cleared by `start`.

## Operation
- States: IDLE, ADDR, CAPT, FIND, DIGIT, CONV, STORE, DONE.
- IDLE/DONE -> ADDR on `start`:
  - Clear `hidden_string`, `err`, and the block index.
  - Set the in-block position (r_m, c_m) to (0,0).
- ADDR:
  - Drive `row` = 4*block_row + r_m and `col` = 4*block_col + c_m.
  - Go to CAPT.
- CAPT:
  - Latch `enc_pix` and `ref_pix` into block buffers E[r_m][c_m] and R[r_m][c_m].
  - Advance (r_m, c_m) in raster order and return to ADDR.
  - After (3,3), go to FIND instead.
- FIND:
  - lm = R[0][0].
  - hm = first R[i][j] in raster order that is not equal to lm (full 24-bit compare). If none exists, hm = lm.
  - If lm > hm, swap lm and hm.
  - pos_lm = first raster position holding lm. pos_hm = first raster position holding hm.
  - If lm == hm, pos_hm = (0,1).
- DIGIT:
  - Visit the 16 positions in raster order, skipping pos_lm and pos_hm. The 14 remaining positions give digits d0..d13 in visiting order.
  - d = (E.G - R.G) mod 256, using green bits [15:8]:
    - 0 -> digit 0
    - +1 (0x01) -> digit 1
    - -1 (0xFF) -> digit 2
    - any other value -> digit 0 and `err` set
- CONV: 14 cycles of Horner evaluation, k = 13 down to 0: acc = acc*3 + d_k.
  - acc is 23 bits; the maximum is 3^14-1 = 4782968.
- STORE:
  - Word = acc[15:0] if acc <= 65535. Otherwise the word is 16'hFFFF and `err` is set.
  - Write the word to slice b.
  - Increment b and reset (r_m, c_m) to (0,0).
  - If b was 255, go to DONE; otherwise go to ADDR.
- DONE:
  - `done` = 1. `row`/`col` hold their last values.
  - `hidden_string` holds its value until the next `start` or reset.

## Timing
- Memory read latency is 1 cycle. An address driven in ADDR is sampled in the following CAPT cycle.
- Per block: 32 (16 x ADDR+CAPT) + 1 FIND + 1 DIGIT + 14 CONV + 1 STORE = 49 cycles.
- Full decode takes 256*49 = 12544 cycles from the first ADDR to entering DONE. `done` is visible on the cycle after the final STORE.
- Reset values of outputs:
  - `row` = 0, `col` = 0
  - `hidden_string` = 0
  - `busy` = 0, `done` = 0, `err` = 0
  - FSM in IDLE
- Reset mid-operation: the run is abandoned immediately and all outputs return to their reset values. A new `start` is required.
- `start` during `busy` is ignored. `start` in DONE restarts the decode and clears `done` and `err` on the same edge.
- The block index wraps after 255 only through DONE. It never writes outside bits [4095:0].

## Test plan
- Decode with no hidden data:
  - Stimulus: `ref_pix` = `enc_pix` = 24'h004000 everywhere, pulse `start`.
  - Required: `done` after 12545 cycles, `hidden_string` = 0, `err` = 0.
- Small value in block 0:
  - Stimulus: ref uniform G = 0x40, so lm == hm and positions (0,0) and (0,1) are skipped. Encoded G at (0,2) = 0x3F and at (0,3) = 0x41; all other pixels equal.
  - Required: bits [15:0] = 16'h0005; every other slice 0.
- Normal Lm/Hm block:
  - Stimulus: block 1 ref with R[0][0].G = 0x80 and R[0][1].G = 0x20, so after the swap lm = 0x20 at (0,1) and hm = 0x80 at (0,0). Encoded G at (0,2) = ref + 1, everything else unchanged.
  - Required: bits [31:16] = 16'h0001.
- Overflow and illegal difference:
  - Stimulus: in block 0, all 14 digits = 2, which gives acc = 4782968. Separately, one pixel with a difference of +2 in block 5.
  - Required: bits [15:0] = 16'hFFFF, and `err` = 1 at DONE.
- Control handling:
  - Stimulus: `start` pulsed while `busy`; later `rst` asserted during the CONV of block 3.
  - Required: the second `start` has no effect. After `rst`, `busy`, `done` and `err` are 0 and `hidden_string` = 0. A fresh `start` then decodes correctly.
